// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO feeding a UART transmitter through a start/done handshake.
// Bytes are queued on a write strobe and popped one per frame while the FSM is idle.
module uart_tx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_wr,
  input  logic [DATA_BITS-1:0] i_wr_data,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [ADDR_BITS:0]   o_count,
  output logic                 o_overflow,
  output logic                 o_tx_start,
  output logic [DATA_BITS-1:0] o_tx_data,
  input  logic                 i_tx_done
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic [ADDR_BITS:0]   CNT_ZERO  = {(ADDR_BITS+1){1'b0}};
  localparam logic [ADDR_BITS:0]   CNT_ONE   = {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [ADDR_BITS:0]   CNT_FULL  = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS-1:0] PTR_ZERO  = {ADDR_BITS{1'b0}};
  localparam logic [ADDR_BITS-1:0] PTR_ONE   = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [DATA_BITS-1:0] DATA_ZERO = {DATA_BITS{1'b0}};

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [1:0]           state_q, state_d;
  logic                 tx_start_q, tx_start_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;

  logic full_s;
  logic empty_s;
  logic wr_accept_s;
  logic pop_s;

  // Flags come from the registered count, so a same-cycle pop never frees room for a write.
  always_comb begin
    full_s      = (count_q == CNT_FULL);
    empty_s     = (count_q == CNT_ZERO);
    wr_accept_s = i_wr & ~full_s;
    pop_s       = (state_q == ST_IDLE) & ~empty_s;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    state_d    = state_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;

    if (wr_accept_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      overflow_d = overflow_q | i_wr;
    end

    case ({wr_accept_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // tx_done is only honoured in WAIT; a pulse in any other state is dropped.
    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          tx_data_d  = mem_q[rd_ptr_q];
          rd_ptr_d   = rd_ptr_q + PTR_ONE;
          tx_start_d = 1'b1;
          state_d    = ST_START;
        end else begin
          tx_start_d = 1'b0;
        end
      end
      ST_START: begin
        tx_start_d = 1'b0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        tx_start_d = 1'b0;
        if (i_tx_done) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        tx_start_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (wr_accept_s) begin
      mem_q[wr_ptr_q] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q   <= PTR_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      count_q    <= CNT_ZERO;
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= DATA_ZERO;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign o_full     = full_s;
  assign o_empty    = empty_s;
  assign o_count    = count_q;
  assign o_overflow = overflow_q;
  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a cycle-by-cycle vector table plus
// hand-written sequences for long frames, bursts and full/overflow/wrap.
module tb_uart_tx_fifo;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_wr = 1'b0;
  logic [7:0] i_wr_data = 8'h00;
  logic       i_tx_done = 1'b0;
  logic       o_full;
  logic       o_empty;
  logic [4:0] o_count;
  logic       o_overflow;
  logic       o_tx_start;
  logic [7:0] o_tx_data;

  int applied = 0;
  int miscompares = 0;

  uart_tx_fifo #(.DATA_BITS(8), .ADDR_BITS(4)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_wr       (i_wr),
    .i_wr_data  (i_wr_data),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_count    (o_count),
    .o_overflow (o_overflow),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .i_tx_done  (i_tx_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic       rst;
    logic       wr;
    logic [7:0] wdata;
    logic       done;
    logic [4:0] e_count;
    logic       e_empty;
    logic       e_full;
    logic       e_ovf;
    logic       e_start;
    logic [7:0] e_data;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic wr, input logic [7:0] wd, input logic dn,
                     input logic [4:0] cnt, input logic emp, input logic ful, input logic ovf,
                     input logic st, input logic [7:0] dat);
    vec_t v;
    v = '{rst, wr, wd, dn, cnt, emp, ful, ovf, st, dat};
    vq.push_back(v);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    applied++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Steps until o_tx_start is seen; checks the step count and the byte presented.
  task automatic wait_start(input logic [7:0] exp, input int exp_wait);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!o_tx_start && n < 20);
    chk($sformatf("start_latency_%02h", exp), n, exp_wait);
    chk($sformatf("tx_data_%02h", exp), int'(o_tx_data), int'(exp));
  endtask

  // Transmitter model: keeps the frame busy for n cycles, then pulses done.
  task automatic hold_done(input logic [7:0] exp, input int n);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (o_tx_start !== 1'b0 || o_tx_data !== exp) bad++;
    end
    chk($sformatf("hold_%02h", exp), bad, 0);
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
  endtask

  initial begin
    vec_t v;
    logic [16:0] act_p, exp_p;
    int bad;

    //  rst wr  wdata  done  cnt emp ful ovf st  data
    add(1, 0, 8'h00, 0,  0, 1, 0, 0, 0, 8'h00);
    add(1, 0, 8'h00, 0,  0, 1, 0, 0, 0, 8'h00);
    add(0, 1, 8'hA5, 0,  1, 0, 0, 0, 0, 8'h00);
    add(0, 0, 8'h00, 0,  0, 1, 0, 0, 1, 8'hA5);
    add(0, 0, 8'h00, 0,  0, 1, 0, 0, 0, 8'hA5);
    add(0, 0, 8'h00, 0,  0, 1, 0, 0, 0, 8'hA5);
    add(0, 0, 8'h00, 1,  0, 1, 0, 0, 0, 8'hA5);
    add(0, 0, 8'h00, 0,  0, 1, 0, 0, 0, 8'hA5);
    add(0, 1, 8'h11, 0,  1, 0, 0, 0, 0, 8'hA5);
    add(0, 1, 8'h22, 0,  1, 0, 0, 0, 1, 8'h11);
    add(0, 1, 8'h33, 0,  2, 0, 0, 0, 0, 8'h11);
    add(0, 0, 8'h00, 0,  2, 0, 0, 0, 0, 8'h11);
    add(0, 0, 8'h00, 1,  2, 0, 0, 0, 0, 8'h11);
    add(0, 1, 8'h3C, 0,  2, 0, 0, 0, 1, 8'h22);
    add(0, 0, 8'h00, 0,  2, 0, 0, 0, 0, 8'h22);
    add(0, 0, 8'h00, 1,  2, 0, 0, 0, 0, 8'h22);
    add(0, 0, 8'h00, 0,  1, 0, 0, 0, 1, 8'h33);
    add(0, 0, 8'h00, 1,  1, 0, 0, 0, 0, 8'h33);
    add(0, 0, 8'h00, 0,  1, 0, 0, 0, 0, 8'h33);
    add(0, 0, 8'h00, 1,  1, 0, 0, 0, 0, 8'h33);
    add(0, 0, 8'h00, 0,  0, 1, 0, 0, 1, 8'h3C);
    add(0, 0, 8'h00, 0,  0, 1, 0, 0, 0, 8'h3C);
    add(0, 0, 8'h00, 1,  0, 1, 0, 0, 0, 8'h3C);
    add(0, 0, 8'h00, 1,  0, 1, 0, 0, 0, 8'h3C);
    add(0, 0, 8'h00, 0,  0, 1, 0, 0, 0, 8'h3C);
    add(0, 1, 8'h44, 0,  1, 0, 0, 0, 0, 8'h3C);
    add(0, 1, 8'h55, 0,  1, 0, 0, 0, 1, 8'h44);
    add(0, 1, 8'h66, 0,  2, 0, 0, 0, 0, 8'h44);
    add(0, 1, 8'h77, 0,  3, 0, 0, 0, 0, 8'h44);
    add(1, 0, 8'h00, 0,  0, 1, 0, 0, 0, 8'h00);
    add(0, 0, 8'h00, 0,  0, 1, 0, 0, 0, 8'h00);
    add(0, 0, 8'h00, 0,  0, 1, 0, 0, 0, 8'h00);

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      i_reset   = v.rst;
      i_wr      = v.wr;
      i_wr_data = v.wdata;
      i_tx_done = v.done;
      step();
      act_p = {o_count, o_empty, o_full, o_overflow, o_tx_start, o_tx_data};
      exp_p = {v.e_count, v.e_empty, v.e_full, v.e_ovf, v.e_start, v.e_data};
      chk($sformatf("vec%0d{cnt,emp,ful,ovf,st,data}", i), int'(act_p), int'(exp_p));
    end
    i_reset = 1'b0; i_wr = 1'b0; i_tx_done = 1'b0;

    // Single byte held for a 50-cycle frame.
    i_wr = 1'b1; i_wr_data = 8'hA5;
    step();
    i_wr = 1'b0;
    chk("single_count_after_write", int'(o_count), 1);
    wait_start(8'hA5, 1);
    hold_done(8'hA5, 50);
    chk("single_count_after_done", int'(o_count), 0);
    chk("single_empty_after_done", int'(o_empty), 1);

    // Burst of three on consecutive cycles.
    i_wr = 1'b1; i_wr_data = 8'h01;
    step();
    i_wr_data = 8'h02;
    step();
    chk("burst_first_start", int'({o_tx_start, o_tx_data}), int'({1'b1, 8'h01}));
    i_wr_data = 8'h03;
    step();
    i_wr = 1'b0;
    chk("burst_count", int'(o_count), 2);
    hold_done(8'h01, 4);
    wait_start(8'h02, 1);
    hold_done(8'h02, 5);
    wait_start(8'h03, 1);
    hold_done(8'h03, 3);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (o_tx_start !== 1'b0) bad++;
    end
    chk("burst_no_extra_start", bad, 0);

    // Full, overflow and pointer wrap with done stalled.
    for (int b = 0; b < 17; b++) begin
      i_wr = 1'b1; i_wr_data = 8'(b);
      step();
    end
    chk("full_flag", int'(o_full), 1);
    chk("full_count", int'(o_count), 16);
    chk("full_no_ovf_yet", int'(o_overflow), 0);
    i_wr_data = 8'hFF;
    step();
    i_wr = 1'b0;
    chk("ovf_set", int'(o_overflow), 1);
    chk("ovf_count", int'(o_count), 16);
    chk("ovf_inflight", int'(o_tx_data), 0);
    hold_done(8'h00, 3);
    for (int b = 1; b < 17; b++) begin
      wait_start(8'(b), 1);
      hold_done(8'(b), 2);
    end
    chk("wrap_drained_count", int'(o_count), 0);
    chk("ovf_sticky", int'(o_overflow), 1);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (o_tx_start !== 1'b0) bad++;
    end
    chk("wrap_no_ff_sent", bad, 0);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    chk("ovf_cleared_by_reset", int'(o_overflow), 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
